// File: rtl/trial_sequencer.sv
// Run/trial scheduler: N_RUN runs x N_TRIAL trials (exploration + replay), reward log readback.
// Latency: control outputs are Moore on state; rd_data registered, 1 cycle. Optional TRIAL_TIMEOUT_EN watchdog.
// Backpressure: none; each phase holds in ACTIVE until net_finish (or watchdog), abort forces IDLE.
module trial_sequencer #(
    parameter int N_RUN   = 10,
    parameter int N_TRIAL = 200,
    parameter int TIMEOUT = 4096
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       abort,
    input  logic       net_finish,
    input  logic       net_rewarded,
    output logic       net_reset,
    output logic       net_active,
    output logic [9:0] phase_idx,
    output logic [9:0] run_idx,
    output logic       run_done,
    output logic       exp_done,
    output logic [8:0] hit_count,
    input  logic [8:0] rd_addr,
    output logic       rd_data,
    output logic       timeout_flag
);

    if (N_RUN < 1 || N_RUN > 1023 || N_TRIAL < 1 || N_TRIAL > 511 || TIMEOUT < 1) begin : g_param_chk
        $error("trial_sequencer: parameter out of range");
    end

    typedef enum logic [2:0] {IDLE, RUN_RST, ACTIVE, GAP, RUN_END, DONE} state_t;

    localparam logic [9:0] PH_END   = 10'(2 * N_TRIAL);
    localparam logic [9:0] RUN_LAST = 10'(N_RUN - 1);
    localparam logic [8:0] TRIAL_LIM = 9'(N_TRIAL);

    state_t     state_q, state_d;
    logic [9:0] phase_idx_q, phase_idx_d;
    logic [9:0] run_idx_q, run_idx_d;
    logic [8:0] hit_count_q, hit_count_d;
    logic       rd_data_q;
    logic       tmo_hit;
    logic       phase_end;
    logic       log_we;
    logic       log_bit;
    logic       launch;

    // Full 9-bit address space; entries >= N_TRIAL are never written or read out.
    logic       rew_mem [0:511];

    assign phase_end = (state_q == ACTIVE) && (net_finish || tmo_hit);
    assign log_bit   = net_finish & net_rewarded;
    assign launch    = ((state_q == IDLE) || (state_q == DONE)) && start && !abort;

`ifdef TRIAL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt_q;
    logic          tmo_flag_q;

    assign tmo_hit      = (state_q == ACTIVE) && !net_finish && (tmo_cnt_q == TW'(TIMEOUT - 1));
    assign timeout_flag = tmo_flag_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt_q  <= '0;
            tmo_flag_q <= 1'b0;
        end else begin
            tmo_cnt_q <= (state_q == ACTIVE) ? tmo_cnt_q + 1'b1 : '0;
            if (launch)
                tmo_flag_q <= 1'b0;
            else if (tmo_hit && !abort)
                tmo_flag_q <= 1'b1;
        end
    end
`else
    assign tmo_hit      = 1'b0;
    assign timeout_flag = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            phase_idx_q <= '0;
            run_idx_q   <= '0;
            hit_count_q <= '0;
        end else begin
            state_q     <= state_d;
            phase_idx_q <= phase_idx_d;
            run_idx_q   <= run_idx_d;
            hit_count_q <= hit_count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: if (start) state_d = RUN_RST;
            RUN_RST:    state_d = ACTIVE;
            ACTIVE:     if (phase_end) state_d = GAP;
            GAP:        state_d = (phase_idx_q + 10'd1 == PH_END) ? RUN_END : ACTIVE;
            RUN_END:    state_d = (run_idx_q == RUN_LAST) ? DONE : RUN_RST;
            default:    state_d = IDLE;
        endcase
        if (abort)
            state_d = IDLE;
    end

    // Counters are cleared on entry to RUN_RST and simply hold on abort.
    always_comb begin
        phase_idx_d = phase_idx_q;
        run_idx_d   = run_idx_q;
        hit_count_d = hit_count_q;
        log_we      = 1'b0;
        if (!abort) begin
            unique case (state_q)
                IDLE, DONE: if (start) begin
                    run_idx_d   = '0;
                    phase_idx_d = '0;
                    hit_count_d = '0;
                end
                ACTIVE: if (phase_end && phase_idx_q[0]) begin
                    log_we      = 1'b1;
                    hit_count_d = hit_count_q + {8'd0, log_bit};
                end
                GAP: phase_idx_d = phase_idx_q + 10'd1;
                RUN_END: if (run_idx_q != RUN_LAST) begin
                    run_idx_d   = run_idx_q + 10'd1;
                    phase_idx_d = '0;
                    hit_count_d = '0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        net_reset  = (state_q == RUN_RST);
        net_active = (state_q == ACTIVE);
        run_done   = (state_q == RUN_END);
        exp_done   = (state_q == DONE);
    end

    assign phase_idx = phase_idx_q;
    assign run_idx   = run_idx_q;
    assign hit_count = hit_count_q;
    assign rd_data   = rd_data_q;

    always_ff @(posedge clk) begin
        if (log_we)
            rew_mem[phase_idx_q[9:1]] <= log_bit;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            rd_data_q <= 1'b0;
        else
            rd_data_q <= (rd_addr < TRIAL_LIM) ? rew_mem[rd_addr] : 1'b0;
    end

endmodule

// File: tb/tb_trial_sequencer.sv
// Directed bench for trial_sequencer with N_RUN=2, N_TRIAL=3, TIMEOUT=16.
module tb_trial_sequencer;

    logic       clk = 1'b0;
    logic       reset_n, start, abort, net_finish, net_rewarded;
    logic       net_reset, net_active, run_done, exp_done, rd_data, timeout_flag;
    logic [9:0] phase_idx, run_idx;
    logic [8:0] hit_count, rd_addr;

    int n_assert = 0;
    int n_fail   = 0;
    int n_rst_pulse  = 0;
    int n_done_pulse = 0;

    trial_sequencer #(.N_RUN(2), .N_TRIAL(3), .TIMEOUT(16)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .net_finish(net_finish), .net_rewarded(net_rewarded),
        .net_reset(net_reset), .net_active(net_active),
        .phase_idx(phase_idx), .run_idx(run_idx),
        .run_done(run_done), .exp_done(exp_done), .hit_count(hit_count),
        .rd_addr(rd_addr), .rd_data(rd_data), .timeout_flag(timeout_flag)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset_n) begin
            if (net_reset) n_rst_pulse++;
            if (run_done)  n_done_pulse++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Entered right after the edge that put the DUT in ACTIVE; leaves after the GAP edge.
    task automatic do_phase(input logic rew, input int nwait, input logic gap_fin,
                            input logic [9:0] exp_ph, input int rd_exp);
        check("ph_active", net_active, 1);
        check("ph_idx", phase_idx, exp_ph);
        repeat (nwait) tick();
        check("ph_hold", net_active, 1);
        net_finish = 1'b1; net_rewarded = rew;
        tick();
        check("gap_inactive", net_active, 0);
        if (rd_exp >= 0) check("rd_rw_same", rd_data, rd_exp);
        net_finish = gap_fin; net_rewarded = 1'b1;
        tick();
        net_finish = 1'b0; net_rewarded = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_net_reset"}, net_reset, 0);
        check({tag, "_net_active"}, net_active, 0);
        check({tag, "_phase_idx"}, phase_idx, 0);
        check({tag, "_run_idx"}, run_idx, 0);
        check({tag, "_run_done"}, run_done, 0);
        check({tag, "_exp_done"}, exp_done, 0);
        check({tag, "_hit_count"}, hit_count, 0);
        check({tag, "_rd_data"}, rd_data, 0);
        check({tag, "_timeout_flag"}, timeout_flag, 0);
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; abort = 1'b0;
        net_finish = 1'b0; net_rewarded = 1'b0; rd_addr = '0;
        repeat (2) tick();
        check_all_zero("rst");
        reset_n = 1'b1;
        tick();
        check("idle_no_reset", net_reset, 0);

        // Run 0: finish during RUN_RST and GAP must be ignored; explorations rewarded but not logged.
        start = 1'b1; tick();
        check("r0_net_reset", net_reset, 1);
        check("r0_run_idx", run_idx, 0);
        start = 1'b0; net_finish = 1'b1;
        tick();
        net_finish = 1'b0;
        check("r0_rst_over", net_reset, 0);
        check("r0_hit_init", hit_count, 0);
        do_phase(1, 4, 0, 10'd0, -1);
        do_phase(1, 4, 1, 10'd1, -1);
        check("r0_hit_mid", hit_count, 1);
        do_phase(0, 0, 0, 10'd2, -1);
        do_phase(1, 4, 0, 10'd3, -1);
        do_phase(1, 2, 0, 10'd4, -1);
        do_phase(1, 4, 0, 10'd5, -1);
        check("r0_run_done", run_done, 1);
        check("r0_phase_end", phase_idx, 6);
        check("r0_hit_final", hit_count, 3);
        check("r0_active_off", net_active, 0);
        tick();
        check("r1_net_reset", net_reset, 1);
        check("r1_run_idx", run_idx, 1);
        check("r1_run_done_pulse", run_done, 0);
        tick();

        // Run 1: replay rewards 1,0,1; trial 1 read in its own write cycle sees the run-0 value.
        check("r1_hit_init", hit_count, 0);
        do_phase(0, 4, 0, 10'd0, -1);
        do_phase(1, 4, 0, 10'd1, -1);
        do_phase(0, 4, 0, 10'd2, -1);
        rd_addr = 9'd1;
        do_phase(0, 4, 0, 10'd3, 1);
        check("rd_after_wr", rd_data, 0);
        do_phase(1, 4, 0, 10'd4, -1);
        do_phase(1, 4, 0, 10'd5, -1);
        check("r1_run_done", run_done, 1);
        check("r1_hit_final", hit_count, 2);
        tick();
        check("exp_done", exp_done, 1);
        check("done_run_idx", run_idx, 1);
        check("done_hit_hold", hit_count, 2);
        check("n_net_reset", n_rst_pulse, 2);
        check("n_run_done", n_done_pulse, 2);

        rd_addr = 9'd0; tick();
        check("rd0", rd_data, 1);
        rd_addr = 9'd1; #1;
        check("rd_latency", rd_data, 1);
        tick();
        check("rd1", rd_data, 0);
        rd_addr = 9'd2; tick();
        check("rd2", rd_data, 1);
        rd_addr = 9'd3; tick();
        check("rd_oob3", rd_data, 0);
        rd_addr = 9'd2; tick();
        rd_addr = 9'd511; tick();
        check("rd_oob511", rd_data, 0);
        repeat (3) tick();
        check("done_hold", exp_done, 1);

        // Abort on phase 3 together with a rewarded finish: no write, counters hold.
        start = 1'b1; tick();
        check("rs_exp_done_drop", exp_done, 0);
        check("rs_run_idx", run_idx, 0);
        start = 1'b0; tick();
        do_phase(0, 1, 0, 10'd0, -1);
        do_phase(1, 1, 0, 10'd1, -1);
        do_phase(0, 1, 0, 10'd2, -1);
        check("ab_pre_active", net_active, 1);
        check("ab_pre_phase", phase_idx, 3);
        abort = 1'b1; net_finish = 1'b1; net_rewarded = 1'b1;
        tick();
        abort = 1'b0; net_finish = 1'b0; net_rewarded = 1'b0;
        check("ab_active_off", net_active, 0);
        check("ab_phase_hold", phase_idx, 3);
        check("ab_hit_hold", hit_count, 1);
        check("ab_run_idx", run_idx, 0);
        rd_addr = 9'd1; tick();
        check("ab_no_write", rd_data, 0);
        check("ab_idle_stays", net_active, 0);
        rd_addr = 9'd0; tick();
        check("ab_rd0", rd_data, 1);
        start = 1'b1; tick();
        check("ab_restart_rst", net_reset, 1);
        check("ab_restart_run", run_idx, 0);
        start = 1'b0; tick();
        check("ab_restart_phase", phase_idx, 0);
        check("ab_restart_hit", hit_count, 0);

        // Asynchronous reset in the middle of an ACTIVE phase.
        do_phase(0, 1, 0, 10'd0, -1);
        tick();
        reset_n = 1'b0; #1;
        check_all_zero("mid_rst");
        #2; reset_n = 1'b1;
        tick();
        check("post_rst_idle", net_active, 0);
        start = 1'b1; tick();
        check("post_rst_run", run_idx, 0);
        check("post_rst_net_reset", net_reset, 1);
        start = 1'b0; tick();
        check("post_rst_active", net_active, 1);

`ifdef TRIAL_TIMEOUT_EN
        repeat (15) tick();
        check("tmo_still_active", net_active, 1);
        check("tmo_flag_clear", timeout_flag, 0);
        tick();
        check("tmo_forced_end", net_active, 0);
        check("tmo_flag_set", timeout_flag, 1);
        tick();
        check("tmo_ph1", phase_idx, 1);
        repeat (15) tick();
        check("tmo_ph1_active", net_active, 1);
        tick();
        check("tmo_ph1_end", net_active, 0);
        rd_addr = 9'd0; tick();
        check("tmo_logged_zero", rd_data, 0);
        check("tmo_hit_zero", hit_count, 0);
        check("tmo_flag_sticky", timeout_flag, 1);
`else
        repeat (20) tick();
        check("wait_active", net_active, 1);
        check("wait_phase", phase_idx, 0);
        check("wait_no_flag", timeout_flag, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
